// File: rtl/sfu_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sfu_buf_arbiter
// Purpose  : Shares one SFU FPU result FIFO between N_REQ write requesters
//            and sequences its read side. A round-robin arbiter admits one
//            valid/ready beat per cycle and writes {source id, payload} into
//            the FIFO. Because the FIFO exports no flags, its occupancy is
//            mirrored here. A 2-entry output buffer absorbs the FIFO's
//            1-cycle read latency and presents a valid/ready master port.
// Ports    : clk, rst_n (async active-low, shared with the FIFO)
//            s_valid/s_ready/s_data    requester side (s_ready one-hot/zero)
//            fifo_wr_en/fifo_wr_data   FIFO write port, entry = {id, data}
//            fifo_rd_en/fifo_rd_data   FIFO pop strobe / registered output
//            m_valid/m_ready/m_data/m_id  output beat
//            fifo_occ                  mirrored FIFO occupancy
// Options  : SFU_BUF_BURST_LOCK_EN adds s_last; a granted requester keeps
//            the grant until it delivers a beat with s_last set.
// Revision : 1.0  initial release
// ============================================================================
module sfu_buf_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int OCC_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            s_valid,
  output logic [N_REQ-1:0]            s_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_data,
`ifdef SFU_BUF_BURST_LOCK_EN
  input  logic [N_REQ-1:0]            s_last,
`endif
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH+ID_W-1:0]  fifo_wr_data,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH+ID_W-1:0]  fifo_rd_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [ID_W-1:0]             m_id,
  output logic [OCC_W-1:0]            fifo_occ
);

  logic [ID_W-1:0]       r_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_inflight;
  logic [1:0]            r_obuf_cnt;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [DATA_WIDTH-1:0] r_tail_data;
  logic [ID_W-1:0]       r_head_id;
  logic [ID_W-1:0]       r_tail_id;

  logic                  w_found;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [ID_W-1:0]       w_grant;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_ptr_next;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [DATA_WIDTH-1:0] w_rd_payload;
  logic [ID_W-1:0]       w_rd_id;

`ifdef SFU_BUF_BURST_LOCK_EN
  logic                  r_locked;
  logic [ID_W-1:0]       r_lock_id;
`endif

  // Round-robin search starting at the pointer; a held burst lock overrides
  // the search so only the locked requester can be granted.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && s_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
`ifdef SFU_BUF_BURST_LOCK_EN
    if (r_locked) begin
      w_found = s_valid[r_lock_id];
      w_grant = r_lock_id;
    end
`endif
  end

  // A full FIFO silently drops writes, so no beat is admitted at full even
  // when a pop is issued in the same cycle. The rst_n term keeps s_ready low
  // while reset is asserted even though s_ready is combinational.
  assign w_full     = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_accept   = rst_n & w_found & ~w_full;
  assign w_ptr_next = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;

  always_comb begin
    s_ready    = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s_ready[i] = w_accept && (w_grant == ID_W'(i));
      if (w_grant == ID_W'(i)) begin
        w_sel_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = {w_grant, w_sel_data};

  // Issue a FIFO read only if the buffer will have room when the data lands:
  // entries held + entries in flight - entry leaving now must stay below 2.
  assign w_pop   = (r_obuf_cnt != 2'd0) & m_ready;
  assign w_rd_en = (r_occ != '0) &
                   (({1'b0, r_obuf_cnt} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  assign fifo_rd_en   = w_rd_en;
  assign w_rd_payload = fifo_rd_data[DATA_WIDTH-1:0];
  assign w_rd_id      = fifo_rd_data[DATA_WIDTH +: ID_W];

  assign m_valid  = (r_obuf_cnt != 2'd0);
  assign m_data   = r_head_data;
  assign m_id     = r_head_id;
  assign fifo_occ = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_occ       <= '0;
      r_inflight  <= 1'b0;
      r_obuf_cnt  <= 2'd0;
      r_head_data <= '0;
      r_tail_data <= '0;
      r_head_id   <= '0;
      r_tail_id   <= '0;
`ifdef SFU_BUF_BURST_LOCK_EN
      r_locked    <= 1'b0;
      r_lock_id   <= '0;
`endif
    end else begin
      if (w_accept) begin
`ifdef SFU_BUF_BURST_LOCK_EN
        // Pointer moves only when the burst closes.
        if (s_last[w_grant]) begin
          r_locked <= 1'b0;
          r_ptr    <= w_ptr_next;
        end else begin
          r_locked  <= 1'b1;
          r_lock_id <= w_grant;
        end
`else
        r_ptr <= w_ptr_next;
`endif
      end

      case ({w_accept, w_rd_en})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase

      r_inflight <= w_rd_en;

      // In-order 2-entry queue: head is presented, tail waits behind it.
      if (r_inflight && !w_pop) begin
        if (r_obuf_cnt == 2'd0) begin
          r_head_data <= w_rd_payload;
          r_head_id   <= w_rd_id;
        end else begin
          r_tail_data <= w_rd_payload;
          r_tail_id   <= w_rd_id;
        end
        r_obuf_cnt <= r_obuf_cnt + 2'd1;
      end else if (!r_inflight && w_pop) begin
        r_head_data <= r_tail_data;
        r_head_id   <= r_tail_id;
        r_obuf_cnt  <= r_obuf_cnt - 2'd1;
      end else if (r_inflight && w_pop) begin
        if (r_obuf_cnt == 2'd1) begin
          r_head_data <= w_rd_payload;
          r_head_id   <= w_rd_id;
        end else begin
          r_head_data <= r_tail_data;
          r_head_id   <= r_tail_id;
          r_tail_data <= w_rd_payload;
          r_tail_id   <= w_rd_id;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sfu_buf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfu_buf_arbiter
// Purpose  : Directed self-checking bench for sfu_buf_arbiter. Contains a
//            behavioural 16-deep FIFO with registered read data; all expected
//            values are hand-derived from the intended behaviour.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sfu_buf_arbiter;
  localparam int N_REQ = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int ID_W  = 2;
  localparam int OCC_W = 5;
  localparam int EW    = DW + ID_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    s_valid;
  logic [N_REQ-1:0]    s_ready;
  logic [N_REQ*DW-1:0] s_data;
`ifdef SFU_BUF_BURST_LOCK_EN
  logic [N_REQ-1:0]    s_last;
`endif
  logic                fifo_wr_en;
  logic [EW-1:0]       fifo_wr_data;
  logic                fifo_rd_en;
  logic [EW-1:0]       fifo_rd_data;
  logic                m_valid;
  logic                m_ready;
  logic [DW-1:0]       m_data;
  logic [ID_W-1:0]     m_id;
  logic [OCC_W-1:0]    fifo_occ;

  int n_vec = 0;
  int n_err = 0;
  int viol  = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sfu_buf_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef SFU_BUF_BURST_LOCK_EN
    .s_last(s_last),
`endif
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .fifo_occ(fifo_occ)
  );

  // Behavioural FIFO: drops writes when full, registered read output.
  logic [EW-1:0] mem [DEPTH];
  logic [3:0]    wp, rp;
  int            cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= 0; fifo_rd_data <= '0;
    end else begin
      if (fifo_wr_en && cnt == DEPTH) viol <= viol + 1;
      if (fifo_rd_en && cnt == 0)     viol <= viol + 1;
      if (fifo_wr_en && cnt < DEPTH) begin mem[wp] <= fifo_wr_data; wp <= wp + 4'd1; end
      if (fifo_rd_en && cnt > 0)     begin fifo_rd_data <= mem[rp]; rp <= rp + 4'd1; end
      cnt <= cnt + ((fifo_wr_en && cnt < DEPTH) ? 1 : 0) - ((fifo_rd_en && cnt > 0) ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int src, input logic [DW-1:0] d);
    s_data[src*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] pat(input int src, input int c);
    return 32'hD000_0000 | DW'(src << 8) | DW'(c);
  endfunction

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  // Pops every output beat and compares it to the bench's expected queue.
  task automatic drain_check(input string tag, input int budget);
    int c;
    c = 0;
    s_valid = '0;
    m_ready = 1'b1;
    while (exp_q.size() > 0 && c < budget) begin
      @(negedge clk);
      if (m_valid) check(tag, {30'd0, m_id, m_data}, {30'd0, exp_q.pop_front()});
      next_cycle();
      c++;
    end
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int tx, rx;
    logic stalled;
    s_valid = 4'hF;
    s_data  = '0;
    m_ready = 1'b1;
`ifdef SFU_BUF_BURST_LOCK_EN
    s_last  = 4'hF;
`endif

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_id", m_id, 0);
    check("rst_occ", fifo_occ, 0);
    next_cycle();
    rst_n = 1'b1;

    // ---------------- round robin, sustained throughput ----------------
    for (int c = 0; c < 12; c++) begin
      s_valid = (c < 8) ? 4'hF : 4'h0;
      for (int i = 0; i < N_REQ; i++) put(i, pat(i, c));
      m_ready = 1'b1;
      @(negedge clk);
      if (c < 8) check("rr_ready", s_ready, 64'(1 << (c % 4)));
      if (c >= 3 && c < 11) begin
        check("rr_m_valid", m_valid, 1);
        check("rr_m_id", m_id, 64'((c - 3) % 4));
        check("rr_m_data", m_data, pat((c - 3) % 4, c - 3));
      end
      if (c == 11) check("rr_idle", m_valid, 0);
      next_cycle();
    end

    // ---------------- single-beat latency ----------------
    for (int c = 0; c < 5; c++) begin
      s_valid = (c == 0) ? 4'b0100 : 4'b0000;
      put(2, 32'hA5A5_A5A5);
      m_ready = 1'b1;
      @(negedge clk);
      case (c)
        0: begin
          check("lat_ready", s_ready, 4'b0100);
          check("lat_wr_en", fifo_wr_en, 1);
          check("lat_wr_data", fifo_wr_data, {2'd2, 32'hA5A5_A5A5});
        end
        1: begin
          check("lat_occ1", fifo_occ, 1);
          check("lat_rd_en", fifo_rd_en, 1);
        end
        2: begin
          check("lat_no_valid", m_valid, 0);
          check("lat_occ0", fifo_occ, 0);
        end
        3: begin
          check("lat_m_valid", m_valid, 1);
          check("lat_m_id", m_id, 2);
          check("lat_m_data", m_data, 32'hA5A5_A5A5);
        end
        default: check("lat_done", m_valid, 0);
      endcase
      next_cycle();
    end

    // ---------------- backpressure, m_ready toggling ----------------
    tx = 0; rx = 0; stalled = 1'b0;
    for (int c = 0; c < 80 && rx < 20; c++) begin
      s_valid = (tx < 20) ? 4'b0010 : 4'b0000;
      put(1, 32'hBEEF_0000 + DW'(tx));
      m_ready = (c % 2 == 0);
      @(negedge clk);
      check("bp_ready", s_ready, (tx < 20) ? 4'b0010 : 4'b0000);
      if (m_valid) begin
        check("bp_m_id", m_id, 1);
        check("bp_m_data", m_data, 32'hBEEF_0000 + DW'(rx));
        if (m_ready) rx++;
      end else if (stalled) begin
        check("bp_hold_valid", m_valid, 1);
      end
      stalled = m_valid && !m_ready;
      next_cycle();
      if (tx < 20) tx++;
    end
    check("bp_count", 64'(rx), 20);
    s_valid = '0;
    @(negedge clk);
    check("bp_empty_valid", m_valid, 0);
    check("bp_empty_occ", fifo_occ, 0);
    next_cycle();

    // ---------------- full FIFO ----------------
    tx = 0;
    for (int c = 0; c < 24; c++) begin
      s_valid = 4'b0001;
      put(0, 32'hF000_0000 + DW'(tx));
      m_ready = 1'b0;
      @(negedge clk);
      check("full_ready", s_ready, (c < 18) ? 4'b0001 : 4'b0000);
      if (c == 23) begin
        check("full_occ", fifo_occ, 16);
        check("full_head", m_data, 32'hF000_0000);
      end
      next_cycle();
      if (c < 18) tx++;
    end
    // one m_ready pulse frees exactly one slot
    put(0, 32'hF000_0000 + DW'(tx));
    m_ready = 1'b1;
    @(negedge clk);
    check("pulse_ready", s_ready, 0);
    check("pulse_rd_en", fifo_rd_en, 1);
    check("pulse_data", m_data, 32'hF000_0000);
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    check("refill_ready", s_ready, 4'b0001);
    next_cycle();
    tx++;
    put(0, 32'hF000_0000 + DW'(tx));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("refull_ready", s_ready, 0);
      check("refull_occ", fifo_occ, 16);
      next_cycle();
    end
    for (int k = 1; k < 19; k++) exp_q.push_back({2'd0, 32'hF000_0000 + DW'(k)});
    drain_check("full_drain", 60);
    @(negedge clk);
    check("full_after_occ", fifo_occ, 0);
    next_cycle();

    // ---------------- reset mid-stream ----------------
    for (int c = 0; c < 5; c++) begin
      s_valid = 4'b1000;
      put(3, 32'h3333_0000 + DW'(c));
      m_ready = 1'b0;
      @(negedge clk);
      check("mr_ready", s_ready, 4'b1000);
      next_cycle();
    end
    s_valid = '0;
    @(negedge clk);
    check("mr_occ", fifo_occ, 3);
    check("mr_valid", m_valid, 1);
    #1;
    rst_n   = 1'b0;
    s_valid = 4'b1000;
    #1;
    check("mr_s_ready", s_ready, 0);
    check("mr_wr_en", fifo_wr_en, 0);
    check("mr_rd_en", fifo_rd_en, 0);
    check("mr_m_valid", m_valid, 0);
    check("mr_m_data", m_data, 0);
    check("mr_m_id", m_id, 0);
    check("mr_fifo_occ", fifo_occ, 0);
    next_cycle();
    rst_n   = 1'b1;
    s_valid = '0;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_valid", m_valid, 0);
      check("post_rst_rd_en", fifo_rd_en, 0);
      next_cycle();
    end

`ifdef SFU_BUF_BURST_LOCK_EN
    // ---------------- burst lock ----------------
    begin
      logic [3:0] vv [7];
      logic [3:0] ll [7];
      logic [3:0] rr [7];
      vv = '{4'b0001, 4'b1011, 4'b1001, 4'b1011, 4'b1011, 4'b1001, 4'b0001};
      ll = '{4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
      rr = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
      for (int c = 0; c < 7; c++) begin
        s_valid = vv[c];
        s_last  = ll[c];
        for (int i = 0; i < N_REQ; i++) put(i, pat(i, 100 + c));
        m_ready = 1'b0;
        @(negedge clk);
        check("lock_ready", s_ready, rr[c]);
        for (int i = 0; i < N_REQ; i++)
          if (rr[c][i]) exp_q.push_back({ID_W'(i), pat(i, 100 + c)});
        next_cycle();
      end
      s_last = 4'hF;
      drain_check("lock_drain", 40);
    end
`endif

    check("fifo_protocol", 64'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
